// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multicycle RV32 subset datapath
// (lw, sw, R-type, addi, beq/bne). It walks FETCH -> DECODE -> EXEC ->
// [MEM] -> [WB] and drives the datapath enables and selects. Unknown
// opcodes and unknown branch funct3 values enter TRAP, which is sticky
// until reset.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   opcode       IR[6:0], stable from DECODE to end of instruction
//   funct3       IR[14:12]
//   zero         ALU zero flag (valid in EXEC)
//   memAck       memory finishes the pending memRead/memWrite this cycle
//   pcWrite, irWrite, regWrite, memRead, memWrite, memToReg
//                datapath enables / selects
//   aluSrcA      0 = old PC, 1 = rs1
//   aluSrcB      00 = rs2, 01 = constant 4, 10 = immediate
//   aluOp        00 = add, 01 = subtract, 10 = decode by funct fields
//   pcSrc        0 = ALU result, 1 = branch-target register
//   illegalInstr sticky trap flag
//   state        current state encoding (debug)
//
// Optional feature: define PERF_COUNT_EN to add the cycleCount and
// instrRetired performance counters.
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       memAck,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       pcSrc,
  output logic       illegalInstr,
  output logic [2:0] state
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0] cycleCount,
  output logic [31:0] instrRetired
`endif
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [2:0] stateReg;
  logic [2:0] stateNext;
  logic       illegalReg;

  // Raw decode of the architectural write enables; gated by reset below.
  logic pcWriteRaw;
  logic irWriteRaw;
  logic regWriteRaw;

  logic isLoad;
  logic isStore;
  logic isRtype;
  logic isImm;
  logic isBranch;
  logic brKnown;
  logic brTaken;

  assign isLoad   = (opcode == OP_LOAD);
  assign isStore  = (opcode == OP_STORE);
  assign isRtype  = (opcode == OP_RTYPE);
  assign isImm    = (opcode == OP_IMM);
  assign isBranch = (opcode == OP_BRANCH);

  // Only beq (000) and bne (001) are implemented.
  assign brKnown = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign brTaken = ((funct3 == 3'b000) &&  zero) ||
                   ((funct3 == 3'b001) && !zero);

  always_comb begin
    stateNext   = FETCH;
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSrc       = 1'b0;

    case (stateReg)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memAck) begin
          irWriteRaw = 1'b1;
          pcWriteRaw = 1'b1;
          stateNext  = DECODE;
        end else begin
          stateNext  = FETCH;
        end
      end

      DECODE: begin
        // PC + imm computed here lands in the branch-target register.
        aluSrcB   = 2'b10;
        stateNext = (isLoad || isStore || isRtype || isImm || isBranch)
                    ? EXEC : TRAP;
      end

      EXEC: begin
        aluSrcA = 1'b1;
        if (isLoad || isStore) begin
          aluSrcB   = 2'b10;
          stateNext = MEM;
        end else if (isRtype) begin
          aluOp     = 2'b10;
          stateNext = WB;
        end else if (isImm) begin
          aluSrcB   = 2'b10;
          stateNext = WB;
        end else if (isBranch) begin
          aluOp      = 2'b01;
          pcSrc      = 1'b1;
          pcWriteRaw = brKnown && brTaken;
          stateNext  = brKnown ? FETCH : TRAP;
        end else begin
          // Opcode changed after DECODE accepted it.
          stateNext = TRAP;
        end
      end

      MEM: begin
        if (isLoad) begin
          memRead   = 1'b1;
          stateNext = memAck ? WB : MEM;
        end else if (isStore) begin
          memWrite  = 1'b1;
          stateNext = memAck ? FETCH : MEM;
        end else begin
          stateNext = TRAP;
        end
      end

      WB: begin
        regWriteRaw = 1'b1;
        memToReg    = isLoad;
        stateNext   = FETCH;
      end

      TRAP: begin
        stateNext = TRAP;
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // A reset cycle must not commit anything architectural, even if the
  // current state would otherwise retire or fetch.
  assign pcWrite  = pcWriteRaw  & ~reset;
  assign irWrite  = irWriteRaw  & ~reset;
  assign regWrite = regWriteRaw & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= FETCH;
      illegalReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (stateNext == TRAP) begin
        illegalReg <= 1'b1;
      end
    end
  end

  assign state        = stateReg;
  assign illegalInstr = illegalReg;

`ifdef PERF_COUNT_EN
  logic retire;

  // Last cycle of an instruction: WB, acknowledged store, or a resolved branch.
  assign retire = (stateReg == WB) ||
                  ((stateReg == MEM) && isStore && memAck) ||
                  ((stateReg == EXEC) && isBranch && brKnown);

  logic [31:0] cycleCountReg;
  logic [31:0] instrRetiredReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycleCountReg   <= 32'd0;
      instrRetiredReg <= 32'd0;
    end else begin
      cycleCountReg <= cycleCountReg + 32'd1;
      if (retire) begin
        instrRetiredReg <= instrRetiredReg + 32'd1;
      end
    end
  end

  assign cycleCount   = cycleCountReg;
  assign instrRetired = instrRetiredReg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed testbench for multicycle_control. Each cycle drives memAck,
// samples state and the packed control vector shortly after, compares both
// against hand-computed values, and then advances one clock. With
// PERF_COUNT_EN defined the performance counters are also checked.
//
// Control vector layout (MSB..LSB):
//   pcWrite irWrite regWrite memRead memWrite memToReg aluSrcA
//   aluSrcB[1:0] aluOp[1:0] pcSrc illegalInstr
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       memAck;

  logic       pcWrite, irWrite, regWrite, memRead, memWrite, memToReg;
  logic       aluSrcA, pcSrc, illegalInstr;
  logic [1:0] aluSrcB, aluOp;
  logic [2:0] state;
`ifdef PERF_COUNT_EN
  logic [31:0] cycleCount, instrRetired;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .zero         (zero),
    .memAck       (memAck),
    .pcWrite      (pcWrite),
    .irWrite      (irWrite),
    .regWrite     (regWrite),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memToReg     (memToReg),
    .aluSrcA      (aluSrcA),
    .aluSrcB      (aluSrcB),
    .aluOp        (aluOp),
    .pcSrc        (pcSrc),
    .illegalInstr (illegalInstr),
    .state        (state)
`ifdef PERF_COUNT_EN
    ,
    .cycleCount   (cycleCount),
    .instrRetired (instrRetired)
`endif
  );

  logic [12:0] ctl;
  assign ctl = {pcWrite, irWrite, regWrite, memRead, memWrite, memToReg,
                aluSrcA, aluSrcB, aluOp, pcSrc, illegalInstr};

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_R = 7'b0110011, OP_ADDI = 7'b0010011,
                         OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  localparam logic [12:0] C_FETCH_WAIT = 13'b0_0_0_1_0_0_0_01_00_0_0;
  localparam logic [12:0] C_FETCH_ACK  = 13'b1_1_0_1_0_0_0_01_00_0_0;
  localparam logic [12:0] C_DECODE     = 13'b0_0_0_0_0_0_0_10_00_0_0;
  localparam logic [12:0] C_EXEC_R     = 13'b0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [12:0] C_EXEC_I     = 13'b0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [12:0] C_BR_TAKEN   = 13'b1_0_0_0_0_0_1_00_01_1_0;
  localparam logic [12:0] C_BR_NOT     = 13'b0_0_0_0_0_0_1_00_01_1_0;
  localparam logic [12:0] C_MEM_RD     = 13'b0_0_0_1_0_0_0_00_00_0_0;
  localparam logic [12:0] C_MEM_WR     = 13'b0_0_0_0_1_0_0_00_00_0_0;
  localparam logic [12:0] C_WB_ALU     = 13'b0_0_1_0_0_0_0_00_00_0_0;
  localparam logic [12:0] C_WB_LW      = 13'b0_0_1_0_0_1_0_00_00_0_0;
  localparam logic [12:0] C_TRAP       = 13'b0_0_0_0_0_0_0_00_00_0_1;
  localparam logic [12:0] C_NONE       = 13'b0_0_0_0_0_0_0_00_00_0_0;

  int errorCount = 0;
  int checkCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive memAck, sample, then advance one clock.
  task automatic runCycle(input string tag, input logic ack,
                          input logic [2:0] expState,
                          input logic [12:0] expCtl);
    memAck = ack;
    #1;
    checkVal({tag, ".state"}, {29'd0, state}, {29'd0, expState});
    checkVal({tag, ".ctl"}, {19'd0, ctl}, {19'd0, expCtl});
    $display("cycle %-16s state=%0d ctl=%b", tag, state, ctl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 7'd0;
    funct3 = 3'd0;
    zero   = 1'b0;
    memAck = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with memAck=1: FETCH values, but no fetch commit.
    runCycle("rst_hold", 1'b1, S_FETCH, C_FETCH_WAIT);
    checkVal("rst_illegal", {31'd0, illegalInstr}, 32'd0);
`ifdef PERF_COUNT_EN
    checkVal("rst_cycles", cycleCount, 32'd0);
    checkVal("rst_retired", instrRetired, 32'd0);
`endif
    reset = 1'b0;

    // R-type, memAck always 1: 0,1,2,4,0
    opcode = OP_R;
    runCycle("r_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("r_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("r_exec", 1'b1, S_EXEC, C_EXEC_R);
    runCycle("r_wb", 1'b1, S_WB, C_WB_ALU);

    // lw with a fetch wait and three MEM wait cycles
    opcode = OP_LW;
    runCycle("lw_fetch_wait", 1'b0, S_FETCH, C_FETCH_WAIT);
    runCycle("lw_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("lw_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("lw_exec", 1'b1, S_EXEC, C_EXEC_I);
    for (int i = 0; i < 3; i++) begin
      runCycle("lw_mem_wait", 1'b0, S_MEM, C_MEM_RD);
    end
    runCycle("lw_mem_ack", 1'b1, S_MEM, C_MEM_RD);
    runCycle("lw_wb", 1'b1, S_WB, C_WB_LW);

    // bne taken (zero=0)
    opcode = OP_BR;
    funct3 = 3'b001;
    zero   = 1'b0;
    runCycle("bne_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("bne_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("bne_t_exec", 1'b1, S_EXEC, C_BR_TAKEN);
    // bne not taken (zero=1)
    zero = 1'b1;
    runCycle("bne_fetch2", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("bne_decode2", 1'b1, S_DECODE, C_DECODE);
    runCycle("bne_nt_exec", 1'b1, S_EXEC, C_BR_NOT);
    // beq taken (zero=1)
    funct3 = 3'b000;
    runCycle("beq_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("beq_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("beq_t_exec", 1'b1, S_EXEC, C_BR_TAKEN);

    // sw with two MEM wait cycles
    opcode = OP_SW;
    runCycle("sw_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("sw_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("sw_exec", 1'b1, S_EXEC, C_EXEC_I);
    runCycle("sw_mem_wait", 1'b0, S_MEM, C_MEM_WR);
    runCycle("sw_mem_wait", 1'b0, S_MEM, C_MEM_WR);
    runCycle("sw_mem_ack", 1'b1, S_MEM, C_MEM_WR);

    // Illegal opcode: TRAP held for 10 cycles despite memAck, then reset
    opcode = OP_BAD;
    runCycle("bad_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("bad_decode", 1'b1, S_DECODE, C_DECODE);
    for (int i = 0; i < 10; i++) begin
      runCycle("trap_hold", 1'b1, S_TRAP, C_TRAP);
    end
    reset = 1'b1;
    runCycle("trap_rst_edge", 1'b1, S_TRAP, C_TRAP);
    runCycle("trap_after_rst", 1'b1, S_FETCH, C_FETCH_WAIT);
    reset = 1'b0;

    // Unknown branch funct3: no pcWrite, then TRAP
    opcode = OP_BR;
    funct3 = 3'b010;
    zero   = 1'b0;
    runCycle("bx_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("bx_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("bx_exec", 1'b1, S_EXEC, C_BR_NOT);
    runCycle("bx_trap", 1'b1, S_TRAP, C_TRAP);
    reset = 1'b1;
    runCycle("bx_rst_edge", 1'b1, S_TRAP, C_TRAP);
    reset = 1'b0;

    // Reset in MEM during a pending sw
    opcode = OP_SW;
    funct3 = 3'b010;
    runCycle("swr_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("swr_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("swr_exec", 1'b1, S_EXEC, C_EXEC_I);
    runCycle("swr_mem_wait", 1'b0, S_MEM, C_MEM_WR);
    reset = 1'b1;
    runCycle("swr_mem_rst", 1'b0, S_MEM, C_MEM_WR);
    runCycle("swr_after_rst", 1'b0, S_FETCH, C_FETCH_WAIT);
    reset = 1'b0;

    // Reset during WB suppresses regWrite
    opcode = OP_R;
    runCycle("wbr_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
    runCycle("wbr_decode", 1'b1, S_DECODE, C_DECODE);
    runCycle("wbr_exec", 1'b1, S_EXEC, C_EXEC_R);
    reset = 1'b1;
    runCycle("wbr_wb_rst", 1'b1, S_WB, C_NONE);
    runCycle("wbr_after_rst", 1'b1, S_FETCH, C_FETCH_WAIT);
    reset = 1'b0;

    // Three back-to-back addi with immediate memAck
    opcode = OP_ADDI;
    for (int i = 0; i < 3; i++) begin
      runCycle("addi_fetch", 1'b1, S_FETCH, C_FETCH_ACK);
      runCycle("addi_decode", 1'b1, S_DECODE, C_DECODE);
      runCycle("addi_exec", 1'b1, S_EXEC, C_EXEC_I);
      runCycle("addi_wb", 1'b1, S_WB, C_WB_ALU);
    end
`ifdef PERF_COUNT_EN
    checkVal("perf_cycles", cycleCount, 32'd12);
    checkVal("perf_retired", instrRetired, 32'd3);
`endif
    checkVal("addi_end_state", {29'd0, state}, {29'd0, S_FETCH});

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
